dec_ctrl: RTL and testbench
===========================

DEC_CTRL -- requirements
Module: dec_ctrl

Interface
REQ-001 SHALL have parameter MAX_CODEWORD_WIDTH, default 32, codeword width (8, 16 or 32).
REQ-002 SHALL have parameter AMBA_WORD, default 32, work-mode word width.
REQ-003 SHALL have parameter DEC_LATENCY, default 2, decoder input-to-output cycles (>=1).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_codeword  in  MAX_CODEWORD_WIDTH  received codeword
- in_mode  in  AMBA_WORD  work mode: 0=8-bit, 1=16-bit, 2=32-bit codeword
- dec_data_in  out  MAX_CODEWORD_WIDTH  to decoder data_in
- dec_work_mod  out  AMBA_WORD  to decoder work_mod
- dec_data_out  in  MAX_CODEWORD_WIDTH  decoder corrected info
- dec_num_of_errors  in  2  decoder error count
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  MAX_CODEWORD_WIDTH  corrected info, zero-extended
- out_num_of_errors  out  2  error count of result
- out_illegal  out  1  request rejected, mode illegal
- cnt_clear  in  1  synchronous statistics clear
- cnt_corrected  out  CNT_WIDTH  results with 1 error
- cnt_uncorrectable  out  CNT_WIDTH  results with 2 or 3 errors

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, DONE; in_ready = 1 only in IDLE.
REQ-007 IDLE, accept edge: SHALL register in_codeword into dec_data_in and in_mode into dec_work_mod.
REQ-008 A mode is legal only if in_mode<=2 and codeword width allows it (mode 1 needs width>=16, mode 2 needs width 32).
REQ-009 Legal accept: SHALL go to WAIT and load wait counter with DEC_LATENCY.
REQ-010 Illegal accept: SHALL go directly to DONE with out_data=0, out_num_of_errors=0, out_illegal=1; decoder outputs ignored; counters unchanged.
REQ-011 WAIT: dec_data_in and dec_work_mod SHALL stay stable; counter decrements once per cycle.
REQ-012 SHALL capture dec_data_out and dec_num_of_errors at the DEC_LATENCY-th rising edge after the accept edge, set out_illegal=0 and enter DONE; out_valid rises after that same edge.
REQ-013 DONE: out_valid=1; out_data, out_num_of_errors, out_illegal SHALL hold until handshake.
REQ-014 DONE with out_ready=1: SHALL return to IDLE on that edge; out_valid drops; out_* keep last values.
REQ-015 out_ready has no effect outside DONE; no new request is accepted in WAIT or DONE.
REQ-016 Capture edge: dec_num_of_errors==1 SHALL increment cnt_corrected; 2 or 3 SHALL increment cnt_uncorrectable; 0 changes neither.
REQ-017 Counters SHALL saturate at all-ones; they SHALL NOT wrap.
REQ-018 cnt_clear=1 SHALL zero both counters on the next edge; it overrides a same-edge increment.
REQ-019 Minimum legal-request period SHALL be DEC_LATENCY+2 cycles with out_ready tied high.

Reset
REQ-020 rst low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_illegal=0, and zero out_data, out_num_of_errors, dec_data_in, dec_work_mod and both counters.
REQ-021 Reset during WAIT or DONE SHALL discard the pending result with no counter update; first accept is possible on the first edge after rst rises.

Verification
REQ-022 Stub decoder returns 32'h5, errors 1; mode 0, codeword 32'hA5 -> out_valid after edge T0+2, out_data 32'h5, out_num_of_errors 1, cnt_corrected 1.
REQ-023 Mode 3 request -> DONE after next edge, out_illegal 1, out_data 0, counters unchanged, dec_* hold request values.
REQ-024 out_ready low 10 cycles in DONE -> out_valid and out_data stable, in_ready 0, in_valid ignored throughout.
REQ-025 CNT_WIDTH 4, 17 requests with errors 2 -> cnt_uncorrectable 15; cnt_clear with an increment on the same edge -> 0.
REQ-026 rst low one cycle after accept -> out_valid 0, counters 0, in_ready 1, no result ever produced.
REQ-027 MAX_CODEWORD_WIDTH 16, mode 2 -> out_illegal 1; mode 1 -> normal decode.

Source files
------------

// File: rtl/dec_ctrl.sv
// dec_ctrl: request/response sequencer around a fixed-latency decoder with error statistics.
module dec_ctrl #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int AMBA_WORD = 32,
  parameter int DEC_LATENCY = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] in_codeword,
  input  logic [AMBA_WORD-1:0]          in_mode,
  output logic [MAX_CODEWORD_WIDTH-1:0] dec_data_in,
  output logic [AMBA_WORD-1:0]          dec_work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] dec_data_out,
  input  logic [1:0]                    dec_num_of_errors,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
  output logic [1:0]                    out_num_of_errors,
  output logic                          out_illegal,
  input  logic                          cnt_clear,
  output logic [CNT_WIDTH-1:0]          cnt_corrected,
  output logic [CNT_WIDTH-1:0]          cnt_uncorrectable
);
  localparam int LW = $clog2(DEC_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] wait_cnt;
  logic legal, accept, capture;
  assign legal = (in_mode == AMBA_WORD'(0)) ||
                 (in_mode == AMBA_WORD'(1) && MAX_CODEWORD_WIDTH >= 16) ||
                 (in_mode == AMBA_WORD'(2) && MAX_CODEWORD_WIDTH == 32);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    accept = in_ready && in_valid;
    capture = state == WAIT && wait_cnt == LW'(1);
    state_nxt = accept ? (legal ? WAIT : DONE) :
                capture ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      dec_data_in <= '0;
      dec_work_mod <= '0;
      out_data <= '0;
      out_num_of_errors <= '0;
      out_illegal <= 1'b0;
      cnt_corrected <= '0;
      cnt_uncorrectable <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) wait_cnt <= wait_cnt - LW'(1);
      if (accept) begin
        dec_data_in <= in_codeword;
        dec_work_mod <= in_mode;
        wait_cnt <= LW'(DEC_LATENCY);
        if (!legal) begin
          out_data <= '0;
          out_num_of_errors <= '0;
          out_illegal <= 1'b1;
        end
      end
      if (capture) begin
        out_data <= dec_data_out;
        out_num_of_errors <= dec_num_of_errors;
        out_illegal <= 1'b0;
      end
      // clear wins over a same-edge increment; counters stick at all-ones
      if (cnt_clear) begin
        cnt_corrected <= '0;
        cnt_uncorrectable <= '0;
      end else if (capture) begin
        if (dec_num_of_errors == 2'd1 && cnt_corrected != '1) cnt_corrected <= cnt_corrected + 1'b1;
        if (dec_num_of_errors[1] && cnt_uncorrectable != '1) cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dec_ctrl.sv
// tb_dec_ctrl: randomized and directed checks of dec_ctrl against a transaction-level model.
module tb_dec_ctrl;
  logic clk = 1'b0;
  logic rst, cnt_clear;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_codeword, a_in_mode, a_dec_data_in, a_dec_work_mod, a_dec_data_out, a_out_data;
  logic [1:0] err_a, a_out_num;
  logic [3:0] a_cnt_corrected, a_cnt_uncorrectable;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [15:0] b_in_codeword, b_dec_data_in, b_dec_data_out, b_out_data;
  logic [31:0] b_in_mode, b_dec_work_mod;
  logic [1:0] err_b, b_out_num;
  logic [3:0] b_cnt_corrected, b_cnt_uncorrectable;

  int n_cmp = 0, n_bad = 0;
  int m_corr = 0, m_unc = 0;

  function automatic logic [31:0] stub(input logic [31:0] d, input logic [31:0] m);
    return (d ^ 32'hA0) & (m == 0 ? 32'hFF : m == 1 ? 32'hFFFF : 32'hFFFF_FFFF);
  endfunction

  logic [31:0] b_stub;
  assign a_dec_data_out = stub(a_dec_data_in, a_dec_work_mod);
  assign b_stub = stub({16'h0, b_dec_data_in}, b_dec_work_mod);
  assign b_dec_data_out = b_stub[15:0];

  dec_ctrl #(.MAX_CODEWORD_WIDTH(32), .AMBA_WORD(32), .DEC_LATENCY(2), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_codeword(a_in_codeword),
    .in_mode(a_in_mode), .dec_data_in(a_dec_data_in), .dec_work_mod(a_dec_work_mod),
    .dec_data_out(a_dec_data_out), .dec_num_of_errors(err_a), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_num_of_errors(a_out_num),
    .out_illegal(a_out_illegal), .cnt_clear(cnt_clear), .cnt_corrected(a_cnt_corrected),
    .cnt_uncorrectable(a_cnt_uncorrectable));

  dec_ctrl #(.MAX_CODEWORD_WIDTH(16), .AMBA_WORD(32), .DEC_LATENCY(3), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_codeword(b_in_codeword),
    .in_mode(b_in_mode), .dec_data_in(b_dec_data_in), .dec_work_mod(b_dec_work_mod),
    .dec_data_out(b_dec_data_out), .dec_num_of_errors(err_b), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_num_of_errors(b_out_num),
    .out_illegal(b_out_illegal), .cnt_clear(cnt_clear), .cnt_corrected(b_cnt_corrected),
    .cnt_uncorrectable(b_cnt_uncorrectable));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_count(input logic [1:0] err);
    if (err == 2'd1) m_corr = m_corr < 15 ? m_corr + 1 : 15;
    if (err >= 2'd2) m_unc = m_unc < 15 ? m_unc + 1 : 15;
  endtask

  task automatic run_req(input logic [31:0] cw, input logic [31:0] mode, input logic [1:0] err, input int hold);
    logic lg;
    logic [31:0] ed;
    int n;
    lg = mode <= 2;
    ed = lg ? stub(cw, mode) : 32'h0;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", a_in_ready); end
    a_in_valid = 1'b1; a_in_codeword = cw; a_in_mode = mode; err_a = err;
    tick();
    a_in_valid = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", a_in_ready); end
    n_cmp++; if (a_dec_data_in !== cw) begin n_bad++; $display("FAIL dec_data_in: got %h want %h", a_dec_data_in, cw); end
    n_cmp++; if (a_dec_work_mod !== mode) begin n_bad++; $display("FAIL dec_work_mod: got %h want %h", a_dec_work_mod, mode); end
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (n != (lg ? 2 : 0)) begin n_bad++; $display("FAIL latency: got %0d want %0d", n, lg ? 2 : 0); end
    if (lg) model_count(err);
    n_cmp++; if (a_out_data !== ed) begin n_bad++; $display("FAIL out_data: got %h want %h", a_out_data, ed); end
    n_cmp++; if (a_out_num !== (lg ? err : 2'd0)) begin n_bad++; $display("FAIL out_num: got %0d want %0d", a_out_num, lg ? err : 2'd0); end
    n_cmp++; if (a_out_illegal !== !lg) begin n_bad++; $display("FAIL out_illegal: got %b want %b", a_out_illegal, !lg); end
    n_cmp++; if (a_cnt_corrected !== 4'(m_corr)) begin n_bad++; $display("FAIL cnt_corr: got %0d want %0d", a_cnt_corrected, m_corr); end
    n_cmp++; if (a_cnt_uncorrectable !== 4'(m_unc)) begin n_bad++; $display("FAIL cnt_unc: got %0d want %0d", a_cnt_uncorrectable, m_unc); end
    for (int i = 0; i < hold; i++) begin
      a_in_valid = 1'b1; a_in_codeword = $urandom;
      tick();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== ed) begin n_bad++; $display("FAIL hold_out: got %b/%h want 1/%h", a_out_valid, a_out_data, ed); end
      n_cmp++; if (a_in_ready !== 1'b0 || a_dec_data_in !== cw) begin n_bad++; $display("FAIL hold_in: got %b/%h want 0/%h", a_in_ready, a_dec_data_in, cw); end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL handshake: got valid %b ready %b want 0 1", a_out_valid, a_in_ready); end
    n_cmp++; if (a_out_data !== ed) begin n_bad++; $display("FAIL post_data: got %h want %h", a_out_data, ed); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_clear = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_codeword = '0; a_in_mode = '0; err_a = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_codeword = '0; b_in_mode = '0; err_b = '0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_illegal !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b%b%b want 100", a_in_ready, a_out_valid, a_out_illegal); end
    n_cmp++; if (a_out_data !== 0 || a_out_num !== 0 || a_dec_data_in !== 0 || a_dec_work_mod !== 0) begin n_bad++; $display("FAIL rst_data: got %h %0d %h %h want 0", a_out_data, a_out_num, a_dec_data_in, a_dec_work_mod); end
    n_cmp++; if (a_cnt_corrected !== 0 || a_cnt_uncorrectable !== 0) begin n_bad++; $display("FAIL rst_cnt: got %0d %0d want 0 0", a_cnt_corrected, a_cnt_uncorrectable); end
    tick(); tick();
    rst = 1'b1;
    tick();
    m_corr = 0; m_unc = 0;
  endtask

  task automatic test_basic();
    run_req(32'hA5, 32'd0, 2'd1, 0);
    n_cmp++; if (a_out_data !== 32'h5 || a_cnt_corrected !== 4'd1) begin n_bad++; $display("FAIL basic: got %h %0d want 5 1", a_out_data, a_cnt_corrected); end
  endtask

  task automatic test_illegal();
    run_req($urandom, 32'd3, 2'd2, 0);
    run_req($urandom, 32'hFFFF_FFFF, 2'd1, 2);
  endtask

  task automatic test_backpressure();
    run_req($urandom, 32'd2, 2'd3, 10);
    run_req($urandom, 32'd3, 2'd0, 10);
  endtask

  task automatic test_back_to_back();
    int last = -1, cnt = 0;
    a_in_mode = 32'd1; err_a = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      a_in_codeword = $urandom;
      tick();
      if (a_out_valid === 1'b1) begin
        if (last >= 0) begin
          n_cmp++; if (i - last != 4) begin n_bad++; $display("FAIL b2b_period: got %0d want 4", i - last); end
        end
        last = i; cnt++;
      end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    n_cmp++; if (cnt != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", cnt); end
    tick();
  endtask

  task automatic test_saturate();
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    m_corr = 0; m_unc = 0;
    n_cmp++; if (a_cnt_corrected !== 0 || a_cnt_uncorrectable !== 0) begin n_bad++; $display("FAIL clear: got %0d %0d want 0 0", a_cnt_corrected, a_cnt_uncorrectable); end
    for (int i = 0; i < 17; i++) run_req($urandom, 32'd0, 2'd2, 0);
    n_cmp++; if (a_cnt_uncorrectable !== 4'd15) begin n_bad++; $display("FAIL saturate: got %0d want 15", a_cnt_uncorrectable); end
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    m_corr = 0; m_unc = 0;
    run_req($urandom, 32'd1, 2'd1, 0);
    a_in_valid = 1'b1; a_in_mode = 32'd2; a_in_codeword = $urandom; err_a = 2'd1;
    tick();
    a_in_valid = 1'b0;
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_capture_valid: got %b want 1", a_out_valid); end
    n_cmp++; if (a_cnt_corrected !== 0 || a_cnt_uncorrectable !== 0) begin n_bad++; $display("FAIL clr_override: got %0d %0d want 0 0", a_cnt_corrected, a_cnt_uncorrectable); end
    a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] cw;
    int n;
    a_in_valid = 1'b1; a_in_mode = 32'd0; a_in_codeword = $urandom; err_a = 2'd1;
    tick();
    a_in_valid = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    m_corr = 0; m_unc = 0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ctrl: got %b %b want 0 1", a_out_valid, a_in_ready); end
    n_cmp++; if (a_cnt_corrected !== 0 || a_dec_data_in !== 0 || a_out_data !== 0) begin n_bad++; $display("FAIL midrst_data: got %0d %h %h want 0", a_cnt_corrected, a_dec_data_in, a_out_data); end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (a_out_valid !== 1'b0 || a_cnt_corrected !== 0) begin n_bad++; $display("FAIL midrst_noresult: got %b %0d want 0 0", a_out_valid, a_cnt_corrected); end
    end
    rst = 1'b0;
    tick();
    cw = $urandom;
    a_in_valid = 1'b1; a_in_codeword = cw; a_in_mode = 32'd0; err_a = 2'd1;
    #3 rst = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b0 || a_dec_data_in !== cw) begin n_bad++; $display("FAIL first_accept: got %b %h want 0 %h", a_in_ready, a_dec_data_in, cw); end
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    model_count(2'd1);
    n_cmp++; if (n != 2 || a_out_data !== stub(cw, 32'd0)) begin n_bad++; $display("FAIL first_result: got %0d %h want 2 %h", n, a_out_data, stub(cw, 32'd0)); end
    n_cmp++; if (a_cnt_corrected !== 4'(m_corr)) begin n_bad++; $display("FAIL first_cnt: got %0d want %0d", a_cnt_corrected, m_corr); end
    a_out_ready = 1'b1; tick(); a_out_ready = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] cw;
    logic [31:0] ex;
    int n;
    b_in_valid = 1'b1; b_in_codeword = 16'($urandom); b_in_mode = 32'd2; err_b = 2'd1;
    tick();
    b_in_valid = 1'b0;
    n_cmp++; if (b_out_valid !== 1'b1 || b_out_illegal !== 1'b1 || b_out_data !== 0) begin n_bad++; $display("FAIL w16_mode2: got %b %b %h want 1 1 0", b_out_valid, b_out_illegal, b_out_data); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    cw = 16'($urandom);
    ex = stub({16'h0, cw}, 32'd1);
    b_in_valid = 1'b1; b_in_codeword = cw; b_in_mode = 32'd1;
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (n != 3) begin n_bad++; $display("FAIL w16_latency: got %0d want 3", n); end
    n_cmp++; if (b_out_illegal !== 1'b0 || b_out_data !== ex[15:0] || b_out_num !== 2'd1) begin n_bad++; $display("FAIL w16_mode1: got %b %h %0d want 0 %h 1", b_out_illegal, b_out_data, b_out_num, ex[15:0]); end
    n_cmp++; if (b_cnt_corrected !== 4'd1) begin n_bad++; $display("FAIL w16_cnt: got %0d want 1", b_cnt_corrected); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] mode;
    for (int i = 0; i < 30; i++) begin
      mode = 32'($urandom_range(0, 4));
      if (mode == 4) mode = 32'h8000_0001;
      run_req($urandom, mode, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_width16();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
